// File: rtl/pci_intr_ctrl.sv
// Multi-source interrupt controller driving the PCI core INT_N pin, configured over AXI4-Lite.
// Defining PCI_INTR_COALESCE_EN builds the HOLDOFF register (0x10) and the coalescing counter.
module pci_intr_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_BITS   = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_SRC-1:0]   src_irq,
    output logic                 intr_n,
    input  logic [ADDR_BITS-1:0] s_awaddr,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [31:0]          s_wdata,
    input  logic [3:0]           s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [ADDR_BITS-1:0] s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [31:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rvalid,
    input  logic                 s_rready
);
    localparam int WI = ADDR_BITS - 2;
    localparam logic [WI-1:0] A_PENDING = WI'(0);
    localparam logic [WI-1:0] A_MASK    = WI'(1);
    localparam logic [WI-1:0] A_MODE    = WI'(2);
    localparam logic [WI-1:0] A_ACTIVE  = WI'(3);
    localparam logic [WI-1:0] A_HOLDOFF = WI'(4);

    function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
        logic [31:0] r;
        r = 32'h0000_0000;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_r, evt_r, lvl_r;
    logic [NUM_SRC-1:0] pending_r, mask_r, mode_r;
    logic [NUM_SRC-1:0] pending_n_s, mask_n_s, mode_n_s, w1c_s, active_s, bm_s, wv_s;
    logic [31:0]        bmask32_s, wbits_s, rd_data_s, rdata_r;
    logic [WI-1:0]      awidx_s, aridx_s;
    logic               en_r, bvalid_r, rvalid_r, intr_r, intr_req_s;
    logic               wr_acc_s, rd_acc_s, wr_map_s, rd_err_s;
    logic [1:0]         bresp_r, rresp_r;
    logic               unused_s;

    assign awidx_s   = s_awaddr[ADDR_BITS-1:2];
    assign aridx_s   = s_araddr[ADDR_BITS-1:2];
    assign bmask32_s = {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}};
    assign wbits_s   = s_wdata & bmask32_s;
    assign bm_s      = bmask32_s[NUM_SRC-1:0];
    assign wv_s      = wbits_s[NUM_SRC-1:0];
    assign wr_acc_s  = en_r & s_awvalid & s_wvalid & ~bvalid_r;
    assign rd_acc_s  = en_r & s_arvalid & ~rvalid_r;
    assign active_s  = pending_r & mask_r;
    assign unused_s  = ^{s_awaddr[1:0], s_araddr[1:0], wbits_s};

    assign s_awready = wr_acc_s;
    assign s_wready  = wr_acc_s;
    assign s_arready = rd_acc_s;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_rvalid  = rvalid_r;
    assign s_rdata   = rdata_r;
    assign s_rresp   = rresp_r;
    assign intr_n    = intr_r;

    // Source synchroniser and detect stage; edge and level both pass one registered stage so their latency matches.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= {NUM_SRC{1'b0}};
            prev_r <= {NUM_SRC{1'b0}};
            evt_r  <= {NUM_SRC{1'b0}};
            lvl_r  <= {NUM_SRC{1'b0}};
        end else begin
            sync_r[0] <= src_irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
            prev_r <= sync_r[SYNC_STAGES-1];
            evt_r  <= sync_r[SYNC_STAGES-1] & ~prev_r;
            lvl_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    // Register write decode and next-state for PENDING/MASK/MODE; a same-cycle edge beats W1C.
    always_comb begin
        mask_n_s = mask_r;
        mode_n_s = mode_r;
        w1c_s    = {NUM_SRC{1'b0}};
        wr_map_s = 1'b0;
        case (awidx_s)
            A_PENDING, A_MASK, A_MODE, A_ACTIVE, A_HOLDOFF: wr_map_s = 1'b1;
            default:                                        wr_map_s = 1'b0;
        endcase
        if (wr_acc_s) begin
            case (awidx_s)
                A_PENDING: w1c_s    = wv_s;
                A_MASK:    mask_n_s = (mask_r & ~bm_s) | wv_s;
                A_MODE:    mode_n_s = (mode_r & ~bm_s) | wv_s;
                default:   w1c_s    = {NUM_SRC{1'b0}};
            endcase
        end else begin
            w1c_s = {NUM_SRC{1'b0}};
        end
        pending_n_s = (mode_r & ((pending_r & ~w1c_s) | evt_r)) | (~mode_r & lvl_r);
    end

    // Status and control registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending_r <= {NUM_SRC{1'b0}};
            mask_r    <= {NUM_SRC{1'b0}};
            mode_r    <= {NUM_SRC{1'b0}};
        end else begin
            pending_r <= pending_n_s;
            mask_r    <= mask_n_s;
            mode_r    <= mode_n_s;
        end
    end

`ifdef PCI_INTR_COALESCE_EN
    logic [15:0] holdoff_r, cnt_r;

    // HOLDOFF register and the saturating count of cycles ACTIVE has been non-zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            holdoff_r <= 16'h0000;
            cnt_r     <= 16'h0000;
        end else begin
            if (wr_acc_s && (awidx_s == A_HOLDOFF)) begin
                holdoff_r <= (holdoff_r & ~bmask32_s[15:0]) | wbits_s[15:0];
            end
            if (active_s == {NUM_SRC{1'b0}}) begin
                cnt_r <= 16'h0000;
            end else if (cnt_r != 16'hFFFF) begin
                cnt_r <= cnt_r + 16'h0001;
            end
        end
    end

    assign intr_req_s = (|active_s) && (cnt_r >= holdoff_r);
`else
    assign intr_req_s = |active_s;
`endif

    // Read data mux; values are those before any write committing in the same cycle.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_err_s  = 1'b0;
        case (aridx_s)
            A_PENDING: rd_data_s = zext(pending_r);
            A_MASK:    rd_data_s = zext(mask_r);
            A_MODE:    rd_data_s = zext(mode_r);
            A_ACTIVE:  rd_data_s = zext(active_s);
`ifdef PCI_INTR_COALESCE_EN
            A_HOLDOFF: rd_data_s = {16'h0000, holdoff_r};
`else
            A_HOLDOFF: rd_data_s = 32'h0000_0000;
`endif
            default:   rd_err_s  = 1'b1;
        endcase
    end

    // AXI4-Lite response channels, output enable after reset, and the registered interrupt pin.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_r     <= 1'b0;
            bvalid_r <= 1'b0;
            bresp_r  <= 2'b00;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            rresp_r  <= 2'b00;
            intr_r   <= 1'b1;
        end else begin
            en_r   <= 1'b1;
            intr_r <= ~intr_req_s;
            if (wr_acc_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_map_s ? 2'b00 : 2'b10;
            end else if (bvalid_r && s_bready) begin
                bvalid_r <= 1'b0;
            end
            if (rd_acc_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
                rresp_r  <= rd_err_s ? 2'b10 : 2'b00;
            end else if (rvalid_r && s_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end
endmodule
